// File: rtl/bk_prefix_sum_stage.sv
// ---------------------------------------------------------------------------
// bk_prefix_sum_stage
//
// Downstream half of the pipelined Brent-Kung adder. It takes the bitwise
// propagate/generate vectors from the upstream stage. Bit 0 of those vectors
// carries the adder carry-in, with P[0]=0 and G[0]=cin. The stage resolves
// the group generates with a Brent-Kung prefix tree and then registers the
// sum and the carry-out. Valid/ready handshakes on both sides allow
// multi-word operands to stream through with backpressure.
//
// Pipeline:
//   S1 captures P_IN/G_IN/IN_LAST.
//   The Brent-Kung tree then runs combinationally.
//   S2 holds SUM/COUT/OUT_LAST.
//
// Parameters:
//   WIDTH      operand width; the P/G vectors are WIDTH+1 bits wide
//
// Ports:
//   CLK        clock, all state on the rising edge
//   RST        synchronous active-high reset
//   IN_VALID   P_IN/G_IN/IN_LAST are valid
//   IN_READY   stage accepts a word this cycle (combinational from OUT_READY)
//   P_IN       bitwise propagate, P_IN[0] must be 0
//   G_IN       bitwise generate, G_IN[0] is the carry-in
//   IN_LAST    sideband tag, passed through unchanged
//   OUT_VALID  result valid
//   OUT_READY  consumer accepts the result
//   SUM        sum bits, SUM[i-1] is adder bit i
//   COUT       carry-out, G[WIDTH:0]
//   OUT_LAST   IN_LAST of this result
//   OVF        two's-complement overflow; present only when the optional
//              macro BK_PREFIX_SUM_OVF_EN is defined
// ---------------------------------------------------------------------------
module bk_prefix_sum_stage #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH:0]   P_IN,
  input  logic [WIDTH:0]   G_IN,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
`ifdef BK_PREFIX_SUM_OVF_EN
  output logic             OVF,
`endif
  output logic             OUT_LAST
);

  localparam int N      = WIDTH + 1;
  localparam int LEVELS = $clog2(N);
  localparam int IW     = $clog2(N);

  logic             r_s1Valid;
  logic [WIDTH:0]   r_s1P;
  logic [WIDTH:0]   r_s1G;
  logic             r_s1Last;
  logic             r_s2Valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_last;
  logic             w_s1Adv;
  logic             w_s2Adv;
  logic [WIDTH:0]   w_gg;
`ifdef BK_PREFIX_SUM_OVF_EN
  logic             r_ovf;
`endif

  // Brent-Kung prefix over (G,P). The up-sweep combines spans of doubling
  // size with black cells, which leaves a full prefix at every index 2^k-1.
  // The down-sweep then fills the remaining indices with gray cells. A gray
  // cell is enough there because only G is consumed downstream. The result
  // is gg[i] = G[i:0].
  function automatic logic [WIDTH:0] bkPrefix(input logic [WIDTH:0] p,
                                               input logic [WIDTH:0] g);
    logic [WIDTH:0] gg;
    logic [WIDTH:0] pp;
    gg = g;
    pp = p;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = (2 ** (l + 1)) - 1; i < N; i += 2 ** (l + 1)) begin
        gg[IW'(i)] = gg[IW'(i)] | (pp[IW'(i)] & gg[IW'(i - 2 ** l)]);
        pp[IW'(i)] = pp[IW'(i)] & pp[IW'(i - 2 ** l)];
      end
    end
    for (int l = LEVELS - 2; l >= 0; l--) begin
      for (int i = 3 * (2 ** l) - 1; i < N; i += 2 ** (l + 1)) begin
        gg[IW'(i)] = gg[IW'(i)] | (pp[IW'(i)] & gg[IW'(i - 2 ** l)]);
      end
    end
    return gg;
  endfunction

  // Handshake. A stage may advance when it is empty or when the stage after
  // it advances. Because of this, IN_READY depends combinationally on
  // OUT_READY.
  always_comb begin
    w_s2Adv   = !r_s2Valid || OUT_READY;
    w_s1Adv   = !r_s1Valid || w_s2Adv;
    IN_READY  = w_s1Adv;
    OUT_VALID = r_s2Valid;
    w_gg      = bkPrefix(r_s1P, r_s1G);
  end

  // Pipeline registers. A valid flag follows its upstream flag whenever its
  // stage advances, and holds otherwise. Data registers load only on a real
  // transfer and otherwise keep their contents. This keeps the outputs
  // stable during a stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1Valid <= 1'b0;
      r_s1P     <= '0;
      r_s1G     <= '0;
      r_s1Last  <= 1'b0;
      r_s2Valid <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_last    <= 1'b0;
`ifdef BK_PREFIX_SUM_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      if (w_s1Adv) begin
        r_s1Valid <= IN_VALID;
      end
      if (w_s1Adv && IN_VALID) begin
        r_s1P    <= P_IN;
        r_s1G    <= G_IN;
        r_s1Last <= IN_LAST;
      end
      if (w_s2Adv) begin
        r_s2Valid <= r_s1Valid;
      end
      if (w_s2Adv && r_s1Valid) begin
        r_sum  <= r_s1P[WIDTH:1] ^ w_gg[WIDTH-1:0];
        r_cout <= w_gg[WIDTH];
        r_last <= r_s1Last;
`ifdef BK_PREFIX_SUM_OVF_EN
        // Signed overflow: the carry into the top bit differs from the
        // carry out of it.
        r_ovf  <= w_gg[WIDTH] ^ w_gg[WIDTH-1];
`endif
      end
    end
  end

  assign SUM      = r_sum;
  assign COUT     = r_cout;
  assign OUT_LAST = r_last;
`ifdef BK_PREFIX_SUM_OVF_EN
  assign OVF      = r_ovf;
`endif

endmodule

// File: tb/tb_bk_prefix_sum_stage.sv
// ---------------------------------------------------------------------------
// tb_bk_prefix_sum_stage
//
// Scoreboard bench for bk_prefix_sum_stage with WIDTH=64. The stimulus tasks
// drive directed operand pairs with hand-computed results. Each word the
// stage accepts pushes its expected result into a queue. An independent
// monitor pops the queue and compares whenever the stage hands a result to
// the consumer. The bench also checks, directly, the reset state, latency,
// stall behaviour and mid-stream reset. When BK_PREFIX_SUM_OVF_EN is defined
// it also checks OVF.
// ---------------------------------------------------------------------------
module tb_bk_prefix_sum_stage;

  localparam int W      = 64;
  localparam int BUDGET = 50;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         last;
    logic         ovf;
  } expT;

  logic         CLK;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W:0]   P_IN;
  logic [W:0]   G_IN;
  logic         IN_LAST;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         OUT_LAST;
`ifdef BK_PREFIX_SUM_OVF_EN
  logic         OVF;
`endif

  expT sbQ[$];
  int  popLog[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cycle      = 0;
  int  acceptCount = 0;

  bk_prefix_sum_stage #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .P_IN(P_IN),
    .G_IN(G_IN),
    .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .SUM(SUM),
    .COUT(COUT),
`ifdef BK_PREFIX_SUM_OVF_EN
    .OVF(OVF),
`endif
    .OUT_LAST(OUT_LAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle++;

  // Monitor: a result transfers on the next rising edge whenever OUT_VALID
  // and OUT_READY are both high at the falling edge. Pop the queue and
  // compare.
  initial begin : monitor
    expT e;
    forever begin
      @(negedge CLK);
      if (!RST && OUT_VALID && OUT_READY) begin
        compared++;
        if (sbQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_output: got sum=%h with nothing expected", SUM);
        end else begin
          e = sbQ.pop_front();
          popLog.push_back(cycle);
          if (SUM !== e.sum || COUT !== e.cout || OUT_LAST !== e.last
`ifdef BK_PREFIX_SUM_OVF_EN
              || OVF !== e.ovf
`endif
             ) begin
            mismatched++;
            $display("[TB] FAIL result: got sum=%h cout=%b last=%b, want sum=%h cout=%b last=%b ovf=%b",
                     SUM, COUT, OUT_LAST, e.sum, e.cout, e.last, e.ovf);
          end
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drives one word and holds it until the stage accepts it. The expected
  // result is queued at that point. Returns at #1 after the accepting edge,
  // with IN_VALID still high.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic last,
                               input logic [W-1:0] expSum, input logic expCout,
                               input logic expOvf, output int stall);
    bit done;
    P_IN     = {a ^ b, 1'b0};
    G_IN     = {a & b, cin};
    IN_LAST  = last;
    IN_VALID = 1'b1;
    stall    = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge CLK);
      if (IN_READY) begin
        sbQ.push_back('{sum: expSum, cout: expCout, last: last, ovf: expOvf});
        acceptCount++;
        done = 1'b1;
      end else begin
        stall++;
        if (stall >= BUDGET) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL accept_timeout: got IN_READY=0 for %0d cycles, want acceptance", stall);
          IN_VALID = 1'b0;
          done = 1'b1;
        end
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < BUDGET) begin
      nextCycle();
      n++;
    end
    checkOutput(name, W'(sbQ.size()), '0);
  endtask

  initial begin : stimulus
    int st;
    int stSum;
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    P_IN      = '0;
    G_IN      = '0;
    IN_LAST   = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) nextCycle();
    RST = 1'b0;

    // Reset state
    @(negedge CLK);
    checkOutput("rst_out_valid", W'(OUT_VALID), '0);
    checkOutput("rst_sum", SUM, '0);
    checkOutput("rst_cout", W'(COUT), '0);
    checkOutput("rst_out_last", W'(OUT_LAST), '0);
    checkOutput("rst_in_ready", W'(IN_READY), 64'd1);
`ifdef BK_PREFIX_SUM_OVF_EN
    checkOutput("rst_ovf", W'(OVF), '0);
`endif
    nextCycle();

    // Test 1: all-ones plus one wraps to 0 with a carry-out. The result is
    // registered one edge after acceptance and is consumed at the edge after
    // that.
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, st);
    IN_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("t1_valid_early", W'(OUT_VALID), '0);
    nextCycle();
    @(negedge CLK);
    checkOutput("t1_valid_latency", W'(OUT_VALID), 64'd1);
    nextCycle();
    waitDrain("t1_drain");

    // Test 2: carry-in only, then a full propagate chain driven by carry-in.
    applyStimulus(64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, st);
    applyStimulus(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0,
                  64'd0, 1'b1, 1'b0, st);
    IN_VALID = 1'b0;
    waitDrain("t2_drain");

    // Test 3: four back-to-back words; only the last one is tagged.
    popLog.delete();
    stSum = 0;
    applyStimulus(64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, st); stSum += st;
    applyStimulus(64'd2, 64'd2, 1'b0, 1'b0, 64'd4, 1'b0, 1'b0, st); stSum += st;
    applyStimulus(64'd3, 64'd3, 1'b0, 1'b0, 64'd6, 1'b0, 1'b0, st); stSum += st;
    applyStimulus(64'd4, 64'd4, 1'b0, 1'b1, 64'd8, 1'b0, 1'b0, st); stSum += st;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    waitDrain("t3_drain");
    checkOutput("t3_in_ready_stalls", W'(stSum), '0);
    checkOutput("t3_out_count", W'(popLog.size()), 64'd4);
    if (popLog.size() == 4)
      checkOutput("t3_consecutive", W'(popLog[3] - popLog[0]), 64'd3);

    // Test 4: continuous input with the consumer stalled. The stage fills
    // with two words and then refuses input. The held result is word 1
    // (10+20). After release, every word drains in order.
    OUT_READY = 1'b0;
    begin
      int base;
      base = acceptCount;
      fork
        begin
          int s;
          applyStimulus(64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0, s);
          applyStimulus(64'd100, 64'd200, 1'b0, 1'b0, 64'd300, 1'b0, 1'b0, s);
          applyStimulus(64'hFF, 64'd1, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0, s);
          applyStimulus(64'd7, 64'd8, 1'b0, 1'b0, 64'd15, 1'b0, 1'b0, s);
          applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
                        64'd0, 1'b1, 1'b1, s);
          IN_VALID = 1'b0;
          IN_LAST  = 1'b0;
        end
        begin
          for (int k = 0; k < BUDGET && acceptCount < base + 2; k++) @(negedge CLK);
          for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checkOutput("t4_stall_in_ready", W'(IN_READY), '0);
            checkOutput("t4_stall_out_valid", W'(OUT_VALID), 64'd1);
            checkOutput("t4_stall_sum", SUM, 64'd30);
          end
          nextCycle();
          OUT_READY = 1'b1;
        end
      join
    end
    waitDrain("t4_drain");

    // Test 5: reset with two words in flight discards them.
    OUT_READY = 1'b0;
    applyStimulus(64'd5, 64'd6, 1'b0, 1'b0, 64'd11, 1'b0, 1'b0, st);
    applyStimulus(64'd9, 64'd9, 1'b0, 1'b1, 64'd18, 1'b0, 1'b0, st);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    RST = 1'b1;
    sbQ.delete();
    nextCycle();
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("t5_out_valid", W'(OUT_VALID), '0);
    checkOutput("t5_sum", SUM, '0);
    checkOutput("t5_cout", W'(COUT), '0);
    checkOutput("t5_in_ready", W'(IN_READY), 64'd1);
    OUT_READY = 1'b1;
    nextCycle();
    applyStimulus(64'h123, 64'h456, 1'b1, 1'b0, 64'h57A, 1'b0, 1'b0, st);
    IN_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("t5_valid_early", W'(OUT_VALID), '0);
    nextCycle();
    @(negedge CLK);
    checkOutput("t5_valid_latency", W'(OUT_VALID), 64'd1);
    nextCycle();
    waitDrain("t5_drain");

    // Test 6: signed overflow cases. OVF is compared only when the port
    // exists.
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1, st);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, st);
    applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, st);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    waitDrain("t6_drain");

    repeat (3) nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
